// File: rtl/tpu_pkg.sv
// ============================================================================
//  tpu_pkg
//  Types and constants shared by the weight feeder and its helpers.
//  Rev 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FLUSH = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/up_counter.sv
// ============================================================================
//  up_counter
//  Loadable up-counter with a terminal flag that marks the last enabled step.
//  Rev 1.0
// ============================================================================
`default_nettype none

module up_counter
  import tpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] w_next;

  assign w_next = r_count + WIDTH'(1);

  // tc is qualified by en so the owner can leave its phase on this very step
  assign tc = en && (w_next == r_limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_limit <= '0;
    end else if (load) begin
      r_count <= '0;
      r_limit <= limit;
    end else if (en) begin
      r_count <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/weight_feeder.sv
// ============================================================================
//  weight_feeder
//  Reads weights from the unified buffer, pushes them into the weight
//  accumulator, then issues matching dequeue strobes once draining is allowed.
//  Rev 1.0
// ============================================================================
`default_nettype none

module weight_feeder
  import tpu_pkg::*;
#(
  parameter int WEIGHT_ACC_WIDTH = 4,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [7:0]               count,
  input  logic                     drain_en,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic signed [DATA_W-1:0] mem_rd_data,
  output logic                     weight_acc_valid_data_in,
  output logic signed [DATA_W-1:0] weight_acc_data_in,
  output logic                     weight_acc_valid_in,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam logic [7:0] C_MAX_N = 8'(WEIGHT_ACC_WIDTH);

  feeder_state_t r_state;
  feeder_state_t w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_push_valid;
  logic                  r_cfg_err;

  logic       w_accept;
  logic       w_load;
  logic [7:0] w_n;
  logic       w_fetch;
  logic       w_drain;
  logic       w_rd_tc;
  logic       w_dr_tc;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_load   = w_accept && (count != 8'd0);
  assign w_n      = (count > C_MAX_N) ? C_MAX_N : count;
  assign w_fetch  = (r_state == S_FETCH);
  assign w_drain  = (r_state == S_DRAIN);

  up_counter #(
    .WIDTH (8)
  ) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .limit (w_n),
    .en    (w_fetch),
    .tc    (w_rd_tc)
  );

  up_counter #(
    .WIDTH (8)
  ) u_dr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .limit (w_n),
    .en    (w_drain),
    .tc    (w_dr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    mem_rd_en           = 1'b0;
    weight_acc_valid_in = 1'b0;
    busy                = 1'b1;
    done                = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = (count == 8'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd_en = 1'b1;
        if (w_rd_tc) begin
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (drain_en) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        weight_acc_valid_in = 1'b1;
        if (w_dr_tc) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_push_valid <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err    <= w_accept && (count > C_MAX_N);
      r_push_valid <= mem_rd_en;
      if (w_load) begin
        r_addr <= base_addr;
      end else if (mem_rd_en) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Read data arrives one cycle after the strobe, aligned with the registered
  // push valid, so the weight is forwarded in that cycle and forced to zero otherwise.
  assign weight_acc_valid_data_in = r_push_valid;
  assign weight_acc_data_in       = r_push_valid ? mem_rd_data : '0;
  assign mem_rd_addr              = mem_rd_en ? r_addr : '0;
  assign cfg_err                  = r_cfg_err;

endmodule

`default_nettype wire
